link_rx_descrambler: RTL and testbench

Receive-side front end of the SATA link layer, sitting between the PHY's 32-bit dword/charisk stream and the link receive state machine. It classifies primitives, expands CONT-suppressed repeats back into a per-cycle primitive stream, and tracks frame boundaries (SOF/EOF). It descrambles in-frame data dwords with the same LFSR sequence the transmitter scrambles with. All outputs are registered, giving one cycle of latency.

---
 rtl/sata_link_pkg.sv | 71 +++++++
 rtl/link_rx_descrambler_if.sv | 31 +++
 rtl/link_lfsr_step.sv | 22 ++
 rtl/link_rx_descrambler.sv | 162 ++++++++++++++++
 tb/tb_link_rx_descrambler.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sata_link_pkg.sv
// Shared SATA link-layer definitions: primitive dwords, primitive enum,
// receive FSM states, scrambler seed and the primitive decoder.
package sata_link_pkg;

  localparam logic [31:0] DW_ALIGN = 32'h7B4A4ABC;
  localparam logic [31:0] DW_CONT  = 32'h9999AA7C;
  localparam logic [31:0] DW_SOF   = 32'h3737B57C;
  localparam logic [31:0] DW_EOF   = 32'hD5D5B57C;
  localparam logic [31:0] DW_HOLD  = 32'hD5D5AA7C;
  localparam logic [31:0] DW_HOLDA = 32'h9595AA7C;
  localparam logic [31:0] DW_SYNC  = 32'hB5B5957C;
  localparam logic [31:0] DW_X_RDY = 32'h5757B57C;
  localparam logic [31:0] DW_R_RDY = 32'h4A4A957C;
  localparam logic [31:0] DW_R_IP  = 32'h5555B57C;
  localparam logic [31:0] DW_R_OK  = 32'h3535B57C;
  localparam logic [31:0] DW_R_ERR = 32'h5656B57C;
  localparam logic [31:0] DW_WTRM  = 32'h5858B57C;
  localparam logic [31:0] DW_DMAT  = 32'h3636B57C;

  localparam logic [3:0]  K_PRIM = 4'b0001;
  localparam logic [3:0]  K_DATA = 4'b0000;

  localparam logic [15:0] LFSR_SEED = 16'hF0F6;

  typedef enum logic [4:0] {
    PRIM_NONE,
    PRIM_ALIGN,
    PRIM_CONT,
    PRIM_SOF,
    PRIM_EOF,
    PRIM_HOLD,
    PRIM_HOLDA,
    PRIM_SYNC,
    PRIM_X_RDY,
    PRIM_R_RDY,
    PRIM_R_IP,
    PRIM_R_OK,
    PRIM_R_ERR,
    PRIM_WTRM,
    PRIM_DMAT,
    PRIM_UNKNOWN
  } prim_e;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_REPEAT
  } rx_state_e;

  function automatic prim_e decode_prim(input logic [31:0] dw);
    prim_e p;
    case (dw)
      DW_ALIGN: p = PRIM_ALIGN;
      DW_CONT:  p = PRIM_CONT;
      DW_SOF:   p = PRIM_SOF;
      DW_EOF:   p = PRIM_EOF;
      DW_HOLD:  p = PRIM_HOLD;
      DW_HOLDA: p = PRIM_HOLDA;
      DW_SYNC:  p = PRIM_SYNC;
      DW_X_RDY: p = PRIM_X_RDY;
      DW_R_RDY: p = PRIM_R_RDY;
      DW_R_IP:  p = PRIM_R_IP;
      DW_R_OK:  p = PRIM_R_OK;
      DW_R_ERR: p = PRIM_R_ERR;
      DW_WTRM:  p = PRIM_WTRM;
      DW_DMAT:  p = PRIM_DMAT;
      default:  p = PRIM_UNKNOWN;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/link_rx_descrambler_if.sv
// PHY-side dword stream in, classified primitive/data stream out.
// No backpressure: every val_in dword is consumed in the cycle it is valid.
interface link_rx_descrambler_if;
  import sata_link_pkg::*;

  logic        val_in;
  logic [31:0] data_in;
  logic [3:0]  charisk_in;

  logic        prim_val;
  prim_e       prim_code;
  logic        data_val;
  logic [31:0] data_out;
  logic        sof;
  logic        eof;
  logic        in_frame;
  logic        err;
  rx_state_e   dbg_state;

  modport slave (
    input  val_in, data_in, charisk_in,
    output prim_val, prim_code, data_val, data_out,
    output sof, eof, in_frame, err, dbg_state
  );

  modport master (
    output val_in, data_in, charisk_in,
    input  prim_val, prim_code, data_val, data_out,
    input  sof, eof, in_frame, err, dbg_state
  );
endinterface

// File: rtl/link_lfsr_step.sv
// One dword step of the SATA scrambler, x^16+x^15+x^13+x^4+1.
// The state is the last 16 sequence bits, oldest in bit 0; the mask is the next 32.
module link_lfsr_step (
  input  logic [15:0] i_state,
  output logic [31:0] o_mask,
  output logic [15:0] o_next_state
);

  logic [47:0] w_seq;

  always_comb begin
    w_seq = {32'h0, i_state};
    for (int n = 16; n < 48; n++) begin
      w_seq[n] = w_seq[n-1] ^ w_seq[n-3] ^ w_seq[n-12] ^ w_seq[n-16];
    end
  end

  // The newest 16 bits of this dword's mask carry the sequence into the next dword.
  assign o_mask       = w_seq[47:16];
  assign o_next_state = w_seq[47:32];

endmodule

// File: rtl/link_rx_descrambler.sv
// SATA link receive front end: primitive classification, CONT expansion,
// SOF/EOF framing and data descrambling, all outputs registered.
module link_rx_descrambler
  import sata_link_pkg::*;
#(
  parameter int DATA_BYTE_WIDTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  link_rx_descrambler_if.slave link
);

  if (DATA_BYTE_WIDTH != 4) begin : g_width_check
    $error("link_rx_descrambler: only DATA_BYTE_WIDTH=4 is supported");
  end

  rx_state_e   r_state,     w_state_nxt;
  prim_e       r_last_prim, w_last_prim_nxt;
  logic        r_last_vld,  w_last_vld_nxt;
  logic        r_in_frame,  w_in_frame_nxt;
  logic [15:0] r_lfsr,      w_lfsr_nxt;

  logic        r_prim_val,  w_prim_val_nxt;
  prim_e       r_prim_code, w_prim_code_nxt;
  logic        r_data_val,  w_data_val_nxt;
  logic [31:0] r_data_out,  w_data_out_nxt;
  logic        r_sof,       w_sof_nxt;
  logic        r_eof,       w_eof_nxt;
  logic        r_err,       w_err_nxt;

  logic [31:0] w_mask;
  logic [15:0] w_lfsr_adv;
  logic        w_is_prim;
  logic        w_is_data;
  prim_e       w_code;

  link_lfsr_step u_lfsr_step (
    .i_state      (r_lfsr),
    .o_mask       (w_mask),
    .o_next_state (w_lfsr_adv)
  );

  assign w_is_prim = (link.charisk_in == K_PRIM);
  assign w_is_data = (link.charisk_in == K_DATA);
  assign w_code    = decode_prim(link.data_in);

  always_comb begin
    w_state_nxt     = r_state;
    w_last_prim_nxt = r_last_prim;
    w_last_vld_nxt  = r_last_vld;
    w_in_frame_nxt  = r_in_frame;
    w_lfsr_nxt      = r_lfsr;
    w_prim_val_nxt  = 1'b0;
    w_prim_code_nxt = PRIM_NONE;
    w_data_val_nxt  = 1'b0;
    w_data_out_nxt  = r_data_out;
    w_sof_nxt       = 1'b0;
    w_eof_nxt       = 1'b0;
    w_err_nxt       = 1'b0;

    if (link.val_in) begin
      if (w_is_prim) begin
        case (w_code)
          PRIM_ALIGN: begin
          end
          PRIM_CONT: begin
            // REPEAT implies last_prim is valid, so one test covers both states.
            if (r_last_vld) begin
              w_state_nxt     = ST_REPEAT;
              w_prim_val_nxt  = 1'b1;
              w_prim_code_nxt = r_last_prim;
            end else begin
              w_err_nxt = 1'b1;
            end
          end
          default: begin
            w_prim_val_nxt  = 1'b1;
            w_prim_code_nxt = w_code;
            w_last_prim_nxt = w_code;
            w_last_vld_nxt  = 1'b1;
            w_state_nxt     = ST_IDLE;
            if (w_code == PRIM_UNKNOWN) begin
              w_err_nxt = 1'b1;
            end
            if (w_code == PRIM_SOF) begin
              w_lfsr_nxt     = LFSR_SEED;
              w_in_frame_nxt = 1'b1;
              w_sof_nxt      = 1'b1;
              w_err_nxt      = r_in_frame;
            end
            if (w_code == PRIM_EOF) begin
              if (r_in_frame) begin
                w_in_frame_nxt = 1'b0;
                w_eof_nxt      = 1'b1;
              end else begin
                w_err_nxt = 1'b1;
              end
            end
            if (w_code == PRIM_SYNC && r_in_frame) begin
              w_in_frame_nxt = 1'b0;
              w_err_nxt      = 1'b1;
            end
          end
        endcase
      end else if (w_is_data) begin
        if (r_state == ST_REPEAT) begin
          w_prim_val_nxt  = 1'b1;
          w_prim_code_nxt = r_last_prim;
        end else if (r_in_frame) begin
          w_data_val_nxt = 1'b1;
          w_data_out_nxt = link.data_in ^ w_mask;
          w_lfsr_nxt     = w_lfsr_adv;
        end else begin
          w_err_nxt = 1'b1;
        end
      end else begin
        w_err_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_last_prim <= PRIM_NONE;
      r_last_vld  <= 1'b0;
      r_in_frame  <= 1'b0;
      r_lfsr      <= LFSR_SEED;
      r_prim_val  <= 1'b0;
      r_prim_code <= PRIM_NONE;
      r_data_val  <= 1'b0;
      r_data_out  <= 32'h0;
      r_sof       <= 1'b0;
      r_eof       <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_last_prim <= w_last_prim_nxt;
      r_last_vld  <= w_last_vld_nxt;
      r_in_frame  <= w_in_frame_nxt;
      r_lfsr      <= w_lfsr_nxt;
      r_prim_val  <= w_prim_val_nxt;
      r_prim_code <= w_prim_code_nxt;
      r_data_val  <= w_data_val_nxt;
      r_data_out  <= w_data_out_nxt;
      r_sof       <= w_sof_nxt;
      r_eof       <= w_eof_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign link.prim_val  = r_prim_val;
  assign link.prim_code = r_prim_code;
  assign link.data_val  = r_data_val;
  assign link.data_out  = r_data_out;
  assign link.sof       = r_sof;
  assign link.eof       = r_eof;
  assign link.in_frame  = r_in_frame;
  assign link.err       = r_err;
  assign link.dbg_state = r_state;

endmodule

// File: tb/tb_link_rx_descrambler.sv
// Bench for link_rx_descrambler: per-scenario tasks queue stimulus and
// expected output vectors, then drive one dword per clock and compare.
module tb_link_rx_descrambler;
  import sata_link_pkg::*;

  localparam int W = 43;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  link_rx_descrambler_if link ();

  link_rx_descrambler #(.DATA_BYTE_WIDTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .link (link)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_q[$];
  logic [36:0]  stim_q[$];
  logic [W-1:0] obs_vec;
  logic [W-1:0] e;
  logic [36:0]  s;

  assign obs_vec = {link.prim_val, (link.prim_val ? link.prim_code : PRIM_NONE),
                    link.data_val, (link.data_val ? link.data_out : 32'h0),
                    link.sof, link.eof, link.in_frame, link.err};

  // Serial reference scrambler: one sequence bit per step, oldest bit in [0].
  function automatic logic [31:0] ref_mask(input logic [15:0] st);
    logic [15:0] w;
    logic [31:0] m;
    logic        b;
    w = st;
    m = 32'h0;
    for (int k = 0; k < 32; k++) begin
      b    = w[15] ^ w[13] ^ w[4] ^ w[0];
      m[k] = b;
      w    = {b, w[15:1]};
    end
    return m;
  endfunction

  task automatic drive(input logic v, input logic [3:0] k, input logic [31:0] d);
    link.val_in     = v;
    link.charisk_in = k;
    link.data_in    = d;
    @(negedge clk);
  endtask

  task automatic add(input logic v, input logic [3:0] k, input logic [31:0] d);
    stim_q.push_back({v, k, d});
  endtask

  task automatic exp_v(input logic pv, input prim_e code, input logic dv,
                       input logic [31:0] dout, input logic so, input logic eo,
                       input logic inf, input logic er);
    exp_q.push_back({pv, code, dv, dout, so, eo, inf, er});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 4'h0, 32'h0);
    drive(1'b0, 4'h0, 32'h0);
    rst = 1'b0;
    exp_v(0, PRIM_NONE, 0, 32'h0, 0, 0, 0, 0);
    e = exp_q.pop_front();
    n_tests++;
    if (obs_vec !== e) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected %h", obs_vec, e);
    end
    n_tests++;
    if (link.data_out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data_out: got %h expected 00000000", link.data_out);
    end
    n_tests++;
    if (link.dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d expected %0d", link.dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_frame_basic();
    add(1, K_PRIM, DW_SOF);  exp_v(1, PRIM_SOF, 0, 32'h0, 1, 0, 1, 0);
    add(1, K_DATA, 32'h0);   exp_v(0, PRIM_NONE, 1, 32'hC2D2768D, 0, 0, 1, 0);
    add(1, K_DATA, 32'h0);   exp_v(0, PRIM_NONE, 1, 32'h1F26B368, 0, 0, 1, 0);
    add(1, K_PRIM, DW_EOF);  exp_v(1, PRIM_EOF, 0, 32'h0, 0, 1, 0, 0);
    add(0, K_PRIM, DW_SOF);  exp_v(0, PRIM_NONE, 0, 32'h0, 0, 0, 0, 0);
    for (int i = 0; stim_q.size() > 0; i++) begin
      s = stim_q.pop_front();
      drive(s[36], s[35:32], s[31:0]);
      e = exp_q.pop_front();
      n_tests++;
      if (obs_vec !== e) begin
        n_fail++;
        $display("FAIL frame_basic step %0d: got %h expected %h", i, obs_vec, e);
      end
    end
  endtask

  task automatic test_hold();
    add(1, K_PRIM, DW_SOF);  exp_v(1, PRIM_SOF, 0, 32'h0, 1, 0, 1, 0);
    add(1, K_DATA, 32'h0);   exp_v(0, PRIM_NONE, 1, 32'hC2D2768D, 0, 0, 1, 0);
    for (int j = 0; j < 3; j++) begin
      add(1, K_PRIM, DW_HOLD); exp_v(1, PRIM_HOLD, 0, 32'h0, 0, 0, 1, 0);
    end
    add(1, K_DATA, 32'h0);   exp_v(0, PRIM_NONE, 1, 32'h1F26B368, 0, 0, 1, 0);
    add(1, K_PRIM, DW_EOF);  exp_v(1, PRIM_EOF, 0, 32'h0, 0, 1, 0, 0);
    for (int i = 0; stim_q.size() > 0; i++) begin
      s = stim_q.pop_front();
      drive(s[36], s[35:32], s[31:0]);
      e = exp_q.pop_front();
      n_tests++;
      if (obs_vec !== e) begin
        n_fail++;
        $display("FAIL hold step %0d: got %h expected %h", i, obs_vec, e);
      end
    end
  endtask

  task automatic test_cont();
    add(1, K_PRIM, DW_R_IP); exp_v(1, PRIM_R_IP, 0, 32'h0, 0, 0, 0, 0);
    add(1, K_PRIM, DW_CONT); exp_v(1, PRIM_R_IP, 0, 32'h0, 0, 0, 0, 0);
    for (int j = 0; j < 5; j++) begin
      add(1, K_DATA, $urandom()); exp_v(1, PRIM_R_IP, 0, 32'h0, 0, 0, 0, 0);
    end
    add(1, K_PRIM, DW_ALIGN); exp_v(0, PRIM_NONE, 0, 32'h0, 0, 0, 0, 0);
    add(1, K_PRIM, DW_R_OK);  exp_v(1, PRIM_R_OK, 0, 32'h0, 0, 0, 0, 0);
    for (int i = 0; stim_q.size() > 0; i++) begin
      s = stim_q.pop_front();
      drive(s[36], s[35:32], s[31:0]);
      e = exp_q.pop_front();
      n_tests++;
      if (obs_vec !== e) begin
        n_fail++;
        $display("FAIL cont_expand step %0d: got %h expected %h", i, obs_vec, e);
      end
    end
  endtask

  task automatic test_sof_restart();
    logic [31:0] d;
    d = $urandom();
    add(1, K_PRIM, DW_SOF);  exp_v(1, PRIM_SOF, 0, 32'h0, 1, 0, 1, 0);
    add(1, K_DATA, d);       exp_v(0, PRIM_NONE, 1, d ^ 32'hC2D2768D, 0, 0, 1, 0);
    add(1, K_PRIM, DW_SOF);  exp_v(1, PRIM_SOF, 0, 32'h0, 1, 0, 1, 1);
    add(1, K_DATA, 32'h0);   exp_v(0, PRIM_NONE, 1, 32'hC2D2768D, 0, 0, 1, 0);
    add(1, K_PRIM, DW_EOF);  exp_v(1, PRIM_EOF, 0, 32'h0, 0, 1, 0, 0);
    for (int i = 0; stim_q.size() > 0; i++) begin
      s = stim_q.pop_front();
      drive(s[36], s[35:32], s[31:0]);
      e = exp_q.pop_front();
      n_tests++;
      if (obs_vec !== e) begin
        n_fail++;
        $display("FAIL sof_restart step %0d: got %h expected %h", i, obs_vec, e);
      end
    end
  endtask

  task automatic test_sync_abort();
    add(1, K_PRIM, DW_SOF);  exp_v(1, PRIM_SOF, 0, 32'h0, 1, 0, 1, 0);
    add(1, K_DATA, 32'h0);   exp_v(0, PRIM_NONE, 1, 32'hC2D2768D, 0, 0, 1, 0);
    add(1, K_PRIM, DW_SYNC); exp_v(1, PRIM_SYNC, 0, 32'h0, 0, 0, 0, 1);
    add(1, K_DATA, 32'h0);   exp_v(0, PRIM_NONE, 0, 32'h0, 0, 0, 0, 1);
    add(1, K_PRIM, DW_SYNC); exp_v(1, PRIM_SYNC, 0, 32'h0, 0, 0, 0, 0);
    for (int i = 0; stim_q.size() > 0; i++) begin
      s = stim_q.pop_front();
      drive(s[36], s[35:32], s[31:0]);
      e = exp_q.pop_front();
      n_tests++;
      if (obs_vec !== e) begin
        n_fail++;
        $display("FAIL sync_abort step %0d: got %h expected %h", i, obs_vec, e);
      end
    end
  endtask

  task automatic test_cont_no_last();
    rst = 1'b1;
    drive(1'b0, 4'h0, 32'h0);
    rst = 1'b0;
    add(1, K_PRIM, DW_CONT);      exp_v(0, PRIM_NONE, 0, 32'h0, 0, 0, 0, 1);
    add(1, K_DATA, 32'h12345678); exp_v(0, PRIM_NONE, 0, 32'h0, 0, 0, 0, 1);
    add(1, K_PRIM, DW_EOF);       exp_v(1, PRIM_EOF, 0, 32'h0, 0, 0, 0, 1);
    add(1, K_PRIM, 32'h1234567C); exp_v(1, PRIM_UNKNOWN, 0, 32'h0, 0, 0, 0, 1);
    add(1, K_PRIM, DW_X_RDY);     exp_v(1, PRIM_X_RDY, 0, 32'h0, 0, 0, 0, 0);
    add(1, K_PRIM, DW_CONT);      exp_v(1, PRIM_X_RDY, 0, 32'h0, 0, 0, 0, 0);
    add(1, K_PRIM, DW_R_RDY);     exp_v(1, PRIM_R_RDY, 0, 32'h0, 0, 0, 0, 0);
    for (int i = 0; stim_q.size() > 0; i++) begin
      s = stim_q.pop_front();
      drive(s[36], s[35:32], s[31:0]);
      e = exp_q.pop_front();
      n_tests++;
      if (obs_vec !== e) begin
        n_fail++;
        $display("FAIL no_last_prim step %0d: got %h expected %h", i, obs_vec, e);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    add(1, K_PRIM, DW_SOF);  exp_v(1, PRIM_SOF, 0, 32'h0, 1, 0, 1, 0);
    add(1, K_DATA, 32'h0);   exp_v(0, PRIM_NONE, 1, 32'hC2D2768D, 0, 0, 1, 0);
    for (int i = 0; stim_q.size() > 0; i++) begin
      s = stim_q.pop_front();
      drive(s[36], s[35:32], s[31:0]);
      e = exp_q.pop_front();
      n_tests++;
      if (obs_vec !== e) begin
        n_fail++;
        $display("FAIL mid_reset_pre step %0d: got %h expected %h", i, obs_vec, e);
      end
    end
    rst = 1'b1;
    drive(1'b1, K_DATA, 32'h0);
    rst = 1'b0;
    exp_v(0, PRIM_NONE, 0, 32'h0, 0, 0, 0, 0);
    e = exp_q.pop_front();
    n_tests++;
    if (obs_vec !== e || link.data_out !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got %h/%h expected %h/00000000", obs_vec, link.data_out, e);
    end
    add(1, K_DATA, 32'h0);    exp_v(0, PRIM_NONE, 0, 32'h0, 0, 0, 0, 1);
    add(1, 4'b0010, DW_SOF);  exp_v(0, PRIM_NONE, 0, 32'h0, 0, 0, 0, 1);
    add(1, 4'b1111, 32'h0);   exp_v(0, PRIM_NONE, 0, 32'h0, 0, 0, 0, 1);
    add(0, K_PRIM, DW_SYNC);  exp_v(0, PRIM_NONE, 0, 32'h0, 0, 0, 0, 0);
    for (int i = 0; stim_q.size() > 0; i++) begin
      s = stim_q.pop_front();
      drive(s[36], s[35:32], s[31:0]);
      e = exp_q.pop_front();
      n_tests++;
      if (obs_vec !== e) begin
        n_fail++;
        $display("FAIL mid_reset_post step %0d: got %h expected %h", i, obs_vec, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] lf;
    logic [31:0] d, m;
    int          n, jn;
    for (int f = 0; f < 6; f++) begin
      add(1, K_PRIM, DW_SOF); exp_v(1, PRIM_SOF, 0, 32'h0, 1, 0, 1, 0);
      lf = LFSR_SEED;
      n  = $urandom_range(3, 12);
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 5))
          0: begin
            add(1, K_PRIM, DW_ALIGN); exp_v(0, PRIM_NONE, 0, 32'h0, 0, 0, 1, 0);
          end
          1: begin
            jn = $urandom_range(1, 3);
            add(1, K_PRIM, DW_HOLD); exp_v(1, PRIM_HOLD, 0, 32'h0, 0, 0, 1, 0);
            add(1, K_PRIM, DW_CONT); exp_v(1, PRIM_HOLD, 0, 32'h0, 0, 0, 1, 0);
            for (int j = 0; j < jn; j++) begin
              add(1, K_DATA, $urandom()); exp_v(1, PRIM_HOLD, 0, 32'h0, 0, 0, 1, 0);
            end
            add(1, K_PRIM, DW_HOLDA); exp_v(1, PRIM_HOLDA, 0, 32'h0, 0, 0, 1, 0);
          end
          default: begin
          end
        endcase
        d  = $urandom();
        m  = ref_mask(lf);
        lf = m[31:16];
        add(1, K_DATA, d); exp_v(0, PRIM_NONE, 1, d ^ m, 0, 0, 1, 0);
      end
      add(1, K_PRIM, DW_EOF); exp_v(1, PRIM_EOF, 0, 32'h0, 0, 1, 0, 0);
    end
    for (int i = 0; stim_q.size() > 0; i++) begin
      s = stim_q.pop_front();
      drive(s[36], s[35:32], s[31:0]);
      e = exp_q.pop_front();
      n_tests++;
      if (obs_vec !== e) begin
        n_fail++;
        $display("FAIL back_to_back step %0d: got %h expected %h", i, obs_vec, e);
      end
    end
  endtask

  initial begin
    link.val_in     = 1'b0;
    link.charisk_in = 4'h0;
    link.data_in    = 32'h0;
    test_reset();
    test_frame_basic();
    test_hold();
    test_cont();
    test_sof_restart();
    test_sync_abort();
    test_cont_no_last();
    test_reset_mid_frame();
    test_back_to_back();
    link.val_in = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
